// File: rtl/cla_slice_sequencer.sv
// Sequencer that performs a WIDTH-bit add/subtract by feeding one external
// SLICE-bit CLA one slice per clock, LSB first, and registering the flags.
module cla_slice_sequencer #(
    parameter int WIDTH = 32,
    parameter int SLICE = 4
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             start_i,
    input  logic             sub_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] result_o,
    output logic             cout_o,
    output logic             ovf_o,
    output logic             zero_o,
    output logic [SLICE-1:0] slice_a_o,
    output logic [SLICE-1:0] slice_b_o,
    output logic             slice_cin_o,
    input  logic [SLICE-1:0] slice_sum_i,
    input  logic             slice_cout_i
);
    localparam int N  = WIDTH / SLICE;
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t            state_q;
    logic [WIDTH-1:0]  a_sh_q, b_sh_q, res_sh_q, result_q;
    logic [CW-1:0]     cnt_q;
    logic              carry_q, a_msb_q, b_msb_q;
    logic              busy_q, done_q, cout_q, ovf_q, zero_q;
    logic [WIDTH-1:0]  res_sh_d, b_eff_d;

    assign b_eff_d  = sub_i ? ~b_i : b_i;
    // New slice enters at the top so the LSB slice ends up at bit 0 after N shifts.
    assign res_sh_d = (res_sh_q >> SLICE) | (WIDTH'(slice_sum_i) << (WIDTH - SLICE));

    assign slice_a_o   = (state_q == RUN) ? a_sh_q[SLICE-1:0] : '0;
    assign slice_b_o   = (state_q == RUN) ? b_sh_q[SLICE-1:0] : '0;
    assign slice_cin_o = (state_q == RUN) ? carry_q : 1'b0;

    assign busy_o   = busy_q;
    assign done_o   = done_q;
    assign result_o = result_q;
    assign cout_o   = cout_q;
    assign ovf_o    = ovf_q;
    assign zero_o   = zero_q;

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q  <= IDLE;
            a_sh_q   <= '0;
            b_sh_q   <= '0;
            res_sh_q <= '0;
            result_q <= '0;
            cnt_q    <= '0;
            carry_q  <= 1'b0;
            a_msb_q  <= 1'b0;
            b_msb_q  <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            cout_q   <= 1'b0;
            ovf_q    <= 1'b0;
            zero_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    done_q <= 1'b0;
                    if (start_i) begin
                        a_sh_q  <= a_i;
                        b_sh_q  <= b_eff_d;
                        carry_q <= sub_i;
                        cnt_q   <= '0;
                        a_msb_q <= a_i[WIDTH-1];
                        b_msb_q <= b_eff_d[WIDTH-1];
                        busy_q  <= 1'b1;
                        state_q <= RUN;
                    end else begin
                        state_q <= IDLE;
                    end
                end
                RUN: begin
                    a_sh_q   <= a_sh_q >> SLICE;
                    b_sh_q   <= b_sh_q >> SLICE;
                    res_sh_q <= res_sh_d;
                    carry_q  <= slice_cout_i;
                    if (cnt_q == CNT_LAST) begin
                        state_q  <= DONE;
                        busy_q   <= 1'b0;
                        done_q   <= 1'b1;
                        result_q <= res_sh_d;
                        cout_q   <= slice_cout_i;
                        // Overflow: like-signed operands give a sum of the other sign.
                        ovf_q    <= (a_msb_q == b_msb_q) && (slice_sum_i[SLICE-1] != a_msb_q);
                        zero_q   <= (res_sh_d == '0);
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_cla_slice_sequencer.sv
// Randomized and directed checks of cla_slice_sequencer against a signed/unsigned
// arithmetic reference model and an ideal CLA slice.
module tb_cla_slice_sequencer;
    localparam int W = 32;
    localparam int S = 4;
    localparam int N = W / S;

    logic         clk = 1'b0;
    logic         rst_n, start, sub;
    logic [W-1:0] a, b, result;
    logic         busy, done, cout, ovf, zero;
    logic [S-1:0] slice_a, slice_b, slice_sum;
    logic         slice_cin, slice_cout;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    // Ideal CLA slice: combinational sum and carry.
    assign {slice_cout, slice_sum} = {1'b0, slice_a} + {1'b0, slice_b} + {4'b0, slice_cin};

    cla_slice_sequencer #(.WIDTH(W), .SLICE(S)) dut (
        .clk_i(clk), .rst_n_i(rst_n), .start_i(start), .sub_i(sub),
        .a_i(a), .b_i(b), .busy_o(busy), .done_o(done), .result_o(result),
        .cout_o(cout), .ovf_o(ovf), .zero_o(zero),
        .slice_a_o(slice_a), .slice_b_o(slice_b), .slice_cin_o(slice_cin),
        .slice_sum_i(slice_sum), .slice_cout_i(slice_cout)
    );

    // Returns {ovf, cout, result} from plain signed/unsigned arithmetic.
    function automatic logic [W+1:0] ref_op(input logic [W-1:0] x, input logic [W-1:0] y,
                                            input logic s);
        longint sx, sy, sres;
        logic [W:0] u;
        logic c, o;
        sx = $signed(x);
        sy = $signed(y);
        if (!s) begin
            u = {1'b0, x} + {1'b0, y};
            c = u[W];
            sres = sx + sy;
        end else begin
            u = {1'b0, x} - {1'b0, y};
            c = (x >= y);
            sres = sx - sy;
        end
        o = (sres > 64'sd2147483647) || (sres < -64'sd2147483648);
        return {o, c, u[W-1:0]};
    endfunction

    // Carry into bit position S*k of the full operation.
    function automatic logic cin_exp(input logic [W-1:0] x, input logic [W-1:0] y,
                                     input logic s, input int k);
        longint unsigned xl, yl, m;
        int j;
        j = S * k;
        if (j == 0) return s;
        m  = (64'd1 << j) - 64'd1;
        xl = {32'd0, x} & m;
        yl = {32'd0, y} & m;
        if (!s) return (xl + yl) >= (64'd1 << j);
        return xl >= yl;
    endfunction

    task automatic pulse_start(input logic [W-1:0] x, input logic [W-1:0] y, input logic s);
        @(negedge clk);
        a = x; b = y; sub = s; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Waits (bounded) for done; lat counts cycles since the accepting edge.
    task automatic wait_done(input int from, output int lat);
        lat = from;
        while (!done && lat < 40) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0; start = 1'b0; sub = 1'b0; a = '0; b = '0;
        repeat (3) @(negedge clk);
        checks++;
        if ({busy, done, cout, ovf, zero} !== 5'b0) begin
            errors++; $display("FAIL reset_flags got %b exp 00000", {busy, done, cout, ovf, zero});
        end
        checks++;
        if (result !== '0) begin
            errors++; $display("FAIL reset_result got %h exp 0", result);
        end
        checks++;
        if ({slice_a, slice_b, slice_cin} !== '0) begin
            errors++; $display("FAIL reset_slices got %h exp 0", {slice_a, slice_b, slice_cin});
        end
        rst_n = 1'b1;
    endtask

    task automatic test_directed;
        logic [W-1:0] ta [4] = '{32'hFFFF_FFFF, 32'd5, 32'h7FFF_FFFF, 32'h8000_0000};
        logic [W-1:0] tb [4] = '{32'd1, 32'd7, 32'd1, 32'd1};
        logic         ts [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
        logic [W-1:0] er [4] = '{32'h0, 32'hFFFF_FFFE, 32'h8000_0000, 32'h7FFF_FFFF};
        logic [2:0]   ef [4] = '{3'b010, 3'b000, 3'b100, 3'b110}; // {ovf,cout,zero}... zero set below
        logic         ez [4] = '{1'b1, 1'b0, 1'b0, 1'b0};
        int lat;
        for (int i = 0; i < 4; i++) begin
            pulse_start(ta[i], tb[i], ts[i]);
            wait_done(1, lat);
            checks++;
            if (lat !== N + 1 || done !== 1'b1) begin
                errors++; $display("FAIL dir%0d_latency got %0d exp %0d", i, lat, N + 1);
            end
            checks++;
            if (result !== er[i]) begin
                errors++; $display("FAIL dir%0d_result got %h exp %h", i, result, er[i]);
            end
            checks++;
            if ({ovf, cout, zero} !== {ef[i][2], ef[i][1], ez[i]}) begin
                errors++; $display("FAIL dir%0d_flags got %b exp %b", i, {ovf, cout, zero},
                                   {ef[i][2], ef[i][1], ez[i]});
            end
            @(negedge clk);
            checks++;
            if (done !== 1'b0 || busy !== 1'b0) begin
                errors++; $display("FAIL dir%0d_done_pulse got %b%b exp 00", i, done, busy);
            end
        end
    endtask

    task automatic test_ignored_start;
        int lat, extra;
        pulse_start(32'h1234_5678, 32'h1111_1111, 1'b0);
        repeat (2) @(negedge clk);
        start = 1'b1; a = 32'hDEAD_0000; b = 32'h0; sub = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(4, lat);
        checks++;
        if (lat !== N + 1 || result !== 32'h2345_6789) begin
            errors++; $display("FAIL ignored_start got lat %0d res %h exp lat %0d res 23456789",
                               lat, result, N + 1);
        end
        extra = 0;
        repeat (15) begin
            @(negedge clk);
            if (done) extra++;
        end
        checks++;
        if (extra !== 0 || busy !== 1'b0) begin
            errors++; $display("FAIL ignored_no_second_done got %0d busy %b exp 0 0", extra, busy);
        end
    endtask

    task automatic test_back_to_back;
        int lat, lat2;
        @(negedge clk);
        a = 32'h1234_5678; b = 32'd1; sub = 1'b0; start = 1'b1;
        @(negedge clk);
        a = '0; b = '0;
        wait_done(1, lat);
        checks++;
        if (lat !== N + 1 || result !== 32'h1234_5679) begin
            errors++; $display("FAIL b2b_first got lat %0d res %h exp lat %0d res 12345679",
                               lat, result, N + 1);
        end
        @(negedge clk);
        start = 1'b0;
        wait_done(1, lat2);
        checks++;
        if (lat2 !== N + 1) begin
            errors++; $display("FAIL b2b_spacing got %0d exp %0d", lat2, N + 1);
        end
        checks++;
        if (result !== '0 || zero !== 1'b1) begin
            errors++; $display("FAIL b2b_second got res %h zero %b exp 0 1", result, zero);
        end
    endtask

    task automatic test_reset_midop;
        int lat, seen;
        pulse_start(32'h0F0F_0F0F, 32'h0101_0101, 1'b0);
        wait_done(1, lat);
        checks++;
        if (result !== 32'h1010_1010) begin
            errors++; $display("FAIL rst_pre_result got %h exp 10101010", result);
        end
        pulse_start(32'hAAAA_5555, 32'h1234_4321, 1'b1);
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        checks++;
        if ({busy, done, cout, ovf, zero, result, slice_a, slice_b, slice_cin} !== '0) begin
            errors++; $display("FAIL rst_midop_outputs got busy %b done %b res %h exp all 0",
                               busy, done, result);
        end
        rst_n = 1'b1;
        seen = 0;
        repeat (12) begin
            @(negedge clk);
            if (done) seen++;
        end
        checks++;
        if (seen !== 0) begin
            errors++; $display("FAIL rst_midop_no_done got %0d exp 0", seen);
        end
        pulse_start(32'd100, 32'd58, 1'b1);
        wait_done(1, lat);
        checks++;
        if (lat !== N + 1 || result !== 32'd42 || cout !== 1'b1) begin
            errors++; $display("FAIL rst_after_op got lat %0d res %h cout %b exp %0d 2a 1",
                               lat, result, cout, N + 1);
        end
    endtask

    task automatic test_random;
        logic [W-1:0] x, y, ey;
        logic         s;
        logic [W+1:0] r;
        for (int i = 0; i < 1000; i++) begin
            x = $urandom;
            y = $urandom;
            case ($urandom_range(0, 5))
                0: y = ~x;
                1: y = x;
                2: x = 32'h8000_0000;
                3: y = 32'h7FFF_FFFF;
                default: ;
            endcase
            s  = 1'($urandom_range(0, 1));
            ey = s ? ~y : y;
            r  = ref_op(x, y, s);
            pulse_start(x, y, s);
            for (int k = 0; k < N; k++) begin
                checks++;
                if ({busy, slice_a, slice_b, slice_cin} !==
                    {1'b1, x[S*k +: S], ey[S*k +: S], cin_exp(x, y, s, k)}) begin
                    errors++;
                    $display("FAIL rnd%0d_slice%0d got %b_%h_%h_%b exp 1_%h_%h_%b", i, k,
                             busy, slice_a, slice_b, slice_cin, x[S*k +: S], ey[S*k +: S],
                             cin_exp(x, y, s, k));
                end
                @(negedge clk);
            end
            checks++;
            if ({done, result, cout, ovf, zero} !==
                {1'b1, r[W-1:0], r[W], r[W+1], (r[W-1:0] == '0)}) begin
                errors++;
                $display("FAIL rnd%0d_result a %h b %h sub %b got done %b res %h c%b o%b z%b exp res %h c%b o%b",
                         i, x, y, s, done, result, cout, ovf, zero, r[W-1:0], r[W], r[W+1]);
            end
        end
    endtask

    initial begin
        test_reset;
        test_directed;
        test_ignored_start;
        test_back_to_back;
        test_reset_midop;
        test_random;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
